counter_b4_mon: RTL and testbench
=================================

// Module: counter_b4_mon
// PURPOSE
//  Downstream monitor for the 4-bit counter: samples b4_Q/b4_rco/b4_load/b4_mode each cycle.
//  - Extends the count: RCO rising edges increment a wide carry counter.
//  - Captures parallel-load values; optionally checks every step against the active mode.
//  - Queues events in a small FIFO drained by a valid/ready consumer (logger/scoreboard side).
// PARAMETERS
//  EXT_W       8  width of extended carry counter ext_count
//  FIFO_DEPTH  4  event FIFO entries (power of 2, >=2)
// PORTS
//  b4_clk      in   1      clock, all logic on posedge
//  b4_reset    in   1      synchronous reset, active-high
//  mon_enable  in   1      monitor enable
//  b4_Q        in   4      counter value under observation
//  b4_rco      in   1      counter ripple-carry out
//  b4_load     in   1      counter parallel-load flag
//  b4_mode     in   2      counter mode: 00 +1, 01 -1, 10 -3, 11 load
//  ext_count   out  EXT_W  number of RCO rising edges seen (mod 2^EXT_W)
//  ext_ovf     out  1      sticky: ext_count wrapped max->0
//  load_val    out  4      last b4_Q sampled while b4_load=1
//  step_err    out  1      sticky: step mismatch detected
//  evt_valid   out  1      FIFO head valid
//  evt_data    out  8      {type[1:0], 2'b00, value[3:0]}; 01 rco, 10 load, 11 step err
//  evt_ready   in   1      consumer accepts head when evt_valid & evt_ready
//  drop_cnt    out  8      events lost (saturates at 8'hFF)
// BEHAVIOUR
//  Reset (b4_reset=1 at posedge): state=IDLE; ext_count=0, ext_ovf=0, load_val=0, step_err=0,
//   drop_cnt=0, FIFO emptied, evt_valid=0, evt_data=0, rco_q=0, prev_Q=0, prev_mode=0.
//   Reset mid-operation discards queued events; a pending handshake is not completed.
//  FSM: IDLE -(mon_enable)-> ARM -(mon_enable)-> RUN; mon_enable=0 in any state -> IDLE.
//   IDLE: no detection, no pushes; counters, flags and FIFO contents held; pops still allowed.
//   ARM: captures prev_Q/prev_mode/rco_q only, no events (one-cycle warm-up).
//   RUN: detection active; prev_Q<=b4_Q, prev_mode<=b4_mode, rco_q<=b4_rco every cycle.
//  Detection (RUN, registered; event visible at evt_valid 1 cycle after the sampling edge):
//   rco event : b4_rco=1 & rco_q=0 -> ext_count+1; 2^EXT_W-1 -> 0 sets ext_ovf. value=b4_Q.
//   load event: b4_load=1 -> load_val<=b4_Q; one event per cycle while high. value=b4_Q.
//   step check: prev_mode 00 expects b4_Q==prev_Q+1, 01 prev_Q-1, 10 prev_Q-3, all mod 16;
//    prev_mode 11 or b4_load=1 -> no check. Mismatch -> step_err=1, event value=b4_Q.
//  Push arbitration: one push per cycle; priority step err > load > rco; each losing
//   event and any push while FIFO full (and not popping) increments drop_cnt (saturating).
//  FIFO: first-word-fall-through; evt_data=head when evt_valid else 8'h00.
//   Pop on evt_valid&evt_ready. Full + pop + push same cycle -> both succeed, no drop.
//   Empty + push -> evt_valid=1 next cycle. Pointers wrap mod FIFO_DEPTH.
//  ext_count updates even if the rco event itself is dropped.
// CONFIGURATION
//  COUNTER_B4_MON_CHK_EN defined: step checker, step_err and type-11 events present.
//  Undefined: no checker logic; step_err tied 0; only rco/load events; arbitration load>rco.
// TESTING
//  T1 reset: drive reset 2 cycles mid-stream with 3 queued events -> all outputs 0, evt_valid=0.
//  T2 mode 00, Q 0..15..0 twice, rco high at Q>=13 -> ext_count=2, 2 rco events, step_err=0.
//  T3 load: mode 11, Q=4'hA, b4_load=1 one cycle -> load_val=A, evt_data=8'h8A; no step err.
//  T4 CHK_EN: mode 01, Q 5->3 -> step_err=1, evt_data=8'hC3; without macro: no event, err=0.
//  T5 FIFO: evt_ready=0, 6 rco events, DEPTH=4 -> 4 queued, drop_cnt=2; then ready=1 drains FIFO order.
//  T6 EXT_W=2: 4 rco edges -> ext_count=0, ext_ovf=1; mon_enable=0 -> counts held, no new events.

Source files
------------

// File: rtl/counter_b4_mon_if.sv
// Event stream from the 4-bit counter monitor to its consumer (logger/scoreboard).
// The monitor drives the FIFO head; the consumer answers with evt_ready.
interface counter_b4_mon_if;
   logic       evt_valid;
   logic [7:0] evt_data;
   logic       evt_ready;

   modport master (output evt_valid, output evt_data, input evt_ready);
   modport slave  (input evt_valid, input evt_data, output evt_ready);
endinterface

// File: rtl/counter_b4_mon.sv
// Monitor for the 4-bit counter: extends the count via RCO edges, captures loads, queues events.
// Define COUNTER_B4_MON_CHK_EN to build the step checker (step_err and type-11 events).
//
// state  | meaning
// S_IDLE | monitor off: no detection or pushes, outputs held, consumer may still drain
// S_ARM  | one-cycle warm-up: capture previous Q/mode/rco only
// S_RUN  | detection active, previous values tracked every cycle
module counter_b4_mon #(
   parameter int EXT_W      = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 b4_clk,
   input  logic                 b4_reset,
   input  logic                 mon_enable,
   input  logic [3:0]           b4_Q,
   input  logic                 b4_rco,
   input  logic                 b4_load,
   input  logic [1:0]           b4_mode,
   output logic [EXT_W-1:0]     ext_count,
   output logic                 ext_ovf,
   output logic [3:0]           load_val,
   output logic                 step_err,
   output logic [7:0]           drop_cnt,
   counter_b4_mon_if.master     evt
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN} state_t;

   state_t           state_q;
   logic             rco_q;
   logic [EXT_W-1:0] ext_q, ext_d;
   logic             ovf_q, ovf_d;
   logic [3:0]       load_val_q;
   logic [7:0]       drop_q, drop_d;
   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_q, rd_q;
   logic [PTR_W:0]   cnt_q, cnt_d;

   logic       active, capture;
   logic       rco_ev, load_ev, err_ev;
   logic       push_req, push_ok, pop;
   logic [7:0] push_data;
   logic [1:0] n_ev, drop_inc;
   logic [8:0] drop_sum;

   assign active  = (state_q == S_RUN) && mon_enable;
   assign capture = (state_q != S_IDLE) && mon_enable;
   assign rco_ev  = active && b4_rco && !rco_q;
   assign load_ev = active && b4_load;

`ifdef COUNTER_B4_MON_CHK_EN
   logic [3:0] prev_val_q, exp_val;
   logic [1:0] prev_mode_q;
   logic       err_q;

   always_comb begin
      exp_val = prev_val_q + 4'd1;
      case (prev_mode_q)
         2'b01:   exp_val = prev_val_q - 4'd1;
         2'b10:   exp_val = prev_val_q - 4'd3;
         default: exp_val = prev_val_q + 4'd1;
      endcase
   end

   assign err_ev = active && !b4_load && (prev_mode_q != 2'b11) && (b4_Q != exp_val);

   always_ff @(posedge b4_clk) begin
      if (b4_reset) begin
         prev_val_q  <= 4'd0;
         prev_mode_q <= 2'b00;
         err_q       <= 1'b0;
      end else begin
         if (capture) begin
            prev_val_q  <= b4_Q;
            prev_mode_q <= b4_mode;
         end
         if (err_ev) err_q <= 1'b1;
      end
   end

   assign step_err = err_q;
`else
   logic unused_mode;
   assign unused_mode = ^b4_mode;
   assign err_ev      = 1'b0;
   assign step_err    = 1'b0;
`endif

   // One winner per cycle; every other simultaneous event is counted as lost.
   assign push_req  = err_ev || load_ev || rco_ev;
   assign push_data = err_ev  ? {2'b11, 2'b00, b4_Q} :
                      load_ev ? {2'b10, 2'b00, b4_Q} :
                                {2'b01, 2'b00, b4_Q};
   assign n_ev      = {1'b0, err_ev} + {1'b0, load_ev} + {1'b0, rco_ev};
   assign pop       = (cnt_q != '0) && evt.evt_ready;
   assign push_ok   = push_req && ((cnt_q != FULL_CNT) || pop);
   assign drop_inc  = (n_ev - {1'b0, push_req}) + {1'b0, push_req && !push_ok};
   assign drop_sum  = {1'b0, drop_q} + {7'b0, drop_inc};

   always_comb begin
      ext_d  = ext_q + EXT_W'(rco_ev);
      ovf_d  = ovf_q || (rco_ev && (&ext_q));
      drop_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
      cnt_d  = cnt_q;
      if (push_ok && !pop)      cnt_d = cnt_q + CNT_ONE;
      else if (!push_ok && pop) cnt_d = cnt_q - CNT_ONE;
   end

   always_ff @(posedge b4_clk) begin
      if (b4_reset) begin
         state_q    <= S_IDLE;
         rco_q      <= 1'b0;
         ext_q      <= '0;
         ovf_q      <= 1'b0;
         load_val_q <= 4'd0;
         drop_q     <= 8'd0;
         wr_q       <= '0;
         rd_q       <= '0;
         cnt_q      <= '0;
      end else begin
         if (!mon_enable) begin
            state_q <= S_IDLE;
         end else begin
            case (state_q)
               S_IDLE:  state_q <= S_ARM;
               S_ARM:   state_q <= S_RUN;
               default: state_q <= S_RUN;
            endcase
         end
         if (capture) rco_q <= b4_rco;
         if (load_ev) load_val_q <= b4_Q;
         ext_q  <= ext_d;
         ovf_q  <= ovf_d;
         drop_q <= drop_d;
         cnt_q  <= cnt_d;
         if (push_ok) wr_q <= wr_q + PTR_ONE;
         if (pop)     rd_q <= rd_q + PTR_ONE;
      end
   end

   // Storage needs no reset: the head is masked whenever the FIFO is empty.
   always_ff @(posedge b4_clk) begin
      if (!b4_reset && push_ok) mem_q[wr_q] <= push_data;
   end

   assign ext_count     = ext_q;
   assign ext_ovf       = ovf_q;
   assign load_val      = load_val_q;
   assign drop_cnt      = drop_q;
   assign evt.evt_valid = (cnt_q != '0);
   assign evt.evt_data  = (cnt_q != '0) ? mem_q[rd_q] : 8'h00;

endmodule

// File: tb/tb_counter_b4_mon.sv
// Directed bench for counter_b4_mon: queue-based reference model checked every cycle,
// plus literal expectations at key points. Two DUTs share stimulus (EXT_W=8 and EXT_W=2).
module tb_counter_b4_mon;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst, en, rco, load, ready;
   logic [3:0] q;
   logic [1:0] mode;

   logic [7:0] ext8, drop8, drop2;
   logic [1:0] ext2;
   logic       ovf8, ovf2, err8, err2;
   logic [3:0] lv8, lv2;

   counter_b4_mon_if ev8 ();
   counter_b4_mon_if ev2 ();
   assign ev8.evt_ready = ready;
   assign ev2.evt_ready = ready;

   counter_b4_mon #(.EXT_W(8), .FIFO_DEPTH(DEPTH)) dut (
      .b4_clk(clk), .b4_reset(rst), .mon_enable(en), .b4_Q(q), .b4_rco(rco),
      .b4_load(load), .b4_mode(mode), .ext_count(ext8), .ext_ovf(ovf8),
      .load_val(lv8), .step_err(err8), .drop_cnt(drop8), .evt(ev8));

   counter_b4_mon #(.EXT_W(2), .FIFO_DEPTH(DEPTH)) dut2 (
      .b4_clk(clk), .b4_reset(rst), .mon_enable(en), .b4_Q(q), .b4_rco(rco),
      .b4_load(load), .b4_mode(mode), .ext_count(ext2), .ext_ovf(ovf2),
      .load_val(lv2), .step_err(err2), .drop_cnt(drop2), .evt(ev2));

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_bad = 0;
   bit chk_on = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: spec rules in plain arithmetic, FIFO as a queue.
   int         m_phase = 0;      // cycles of enable seen: 0 off, 1 warming, 2 running
   int         m_edges = 0;
   int         m_loadval = 0;
   bit         m_err = 0;
   int         m_drop = 0;
   int         m_prevq = 0, m_prevmode = 0;
   bit         m_rco = 0;
   logic [7:0] m_q [$];
   bit         a_act, a_rco, a_load, a_err, a_pop;
   int         a_nev, a_delta, a_type;

   always @(posedge clk) begin
      if (rst) begin
         m_phase = 0; m_edges = 0; m_loadval = 0; m_err = 0; m_drop = 0;
         m_prevq = 0; m_prevmode = 0; m_rco = 0;
         m_q.delete();
      end else begin
         a_act  = (m_phase == 2) && en;
         a_rco  = a_act && rco && !m_rco;
         a_load = a_act && load;
         a_err  = 1'b0;
`ifdef COUNTER_B4_MON_CHK_EN
         if (a_act && !load && m_prevmode != 3) begin
            a_delta = (m_prevmode == 0) ? 1 : (m_prevmode == 1) ? -1 : -3;
            if (int'(q) != (m_prevq + a_delta + 16) % 16) a_err = 1'b1;
         end
`endif
         a_pop = (m_q.size() > 0) && ready;
         if (a_pop) void'(m_q.pop_front());
         if (a_rco)  m_edges++;
         if (a_load) m_loadval = int'(q);
         if (a_err)  m_err = 1'b1;
         a_nev = int'(a_rco) + int'(a_load) + int'(a_err);
         if (a_nev > 0) begin
            a_type = a_err ? 3 : a_load ? 2 : 1;
            m_drop += a_nev - 1;
            if (m_q.size() < DEPTH) m_q.push_back({a_type[1:0], 2'b00, q});
            else m_drop++;
            if (m_drop > 255) m_drop = 255;
         end
         if (m_phase != 0 && en) begin
            m_prevq = int'(q); m_prevmode = int'(mode); m_rco = rco;
         end
         if (!en) m_phase = 0;
         else if (m_phase < 2) m_phase++;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("ext_count",  ext8,  m_edges % 256);
         chk("ext_ovf",    ovf8,  (m_edges >= 256) ? 1 : 0);
         chk("ext2_count", ext2,  m_edges % 4);
         chk("ext2_ovf",   ovf2,  (m_edges >= 4) ? 1 : 0);
         chk("load_val",   lv8,   m_loadval);
         chk("step_err",   err8,  m_err);
         chk("drop_cnt",   drop8, m_drop);
         chk("evt_valid",  ev8.evt_valid, (m_q.size() > 0) ? 1 : 0);
         chk("evt_data",   ev8.evt_data,  (m_q.size() > 0) ? m_q[0] : 8'h00);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rco_pulse(input logic [3:0] v);
      q = v; rco = 1'b1; step();
      rco = 1'b0; step();
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; q = 4'd0; rco = 1'b0; load = 1'b0; mode = 2'b00; ready = 1'b1;
      step();
      chk_on = 1'b1;
      step();
      chk("rst_ext", ext8, 0);
      chk("rst_valid", ev8.evt_valid, 0);
      rst = 1'b0;

      // T2: mode 00 count through two wraps, rco high for Q>=13
      en = 1'b1; mode = 2'b00;
      for (int i = 0; i <= 32; i++) begin
         q = 4'(i % 16); rco = (q >= 4'd13); step();
         if (i == 13) chk("t2_first_rco_evt", ev8.evt_data, 8'h4D);
      end
      chk("t2_ext", ext8, 2);
      chk("t2_err", err8, 0);
      chk("t2_ext2", ext2, 2);

      // T3: parallel load
      ready = 1'b0; mode = 2'b11; q = 4'hA; load = 1'b1; rco = 1'b0; step();
      chk("t3_load_val", lv8, 4'hA);
      chk("t3_evt", ev8.evt_data, 8'h8A);
      load = 1'b0; step();
      ready = 1'b1; step();
      chk("t3_drained", ev8.evt_valid, 0);

      // legal mode 10 steps: A -> 7 -> 4
      mode = 2'b10; q = 4'hA; step();
      q = 4'h7; step();
      mode = 2'b11; q = 4'h4; step();

      // T4: mode 01 from 5 to 3 is a bad step
      mode = 2'b01; q = 4'h5; step();
      mode = 2'b11; q = 4'h3; step();
`ifdef COUNTER_B4_MON_CHK_EN
      chk("t4_err", err8, 1);
      chk("t4_evt", ev8.evt_data, 8'hC3);
`else
      chk("t4_err", err8, 0);
      chk("t4_valid", ev8.evt_valid, 0);
`endif
      step();

      // T5: six rco events into a 4-deep FIFO with the consumer stalled
      ready = 1'b0;
      for (int k = 1; k <= 6; k++) rco_pulse(4'(k));
      chk("t5_drop", drop8, 2);
      chk("t5_head", ev8.evt_data, 8'h41);
      chk("t5_ext", ext8, 8);
      // full + pop + push in one cycle: no loss
      q = 4'h7; rco = 1'b1; ready = 1'b1; step();
      chk("t5_fullpush_drop", drop8, 2);
      chk("t5_head2", ev8.evt_data, 8'h42);
      rco = 1'b0;
      for (int k = 0; k < 5; k++) step();
      chk("t5_empty", ev8.evt_valid, 0);
      chk("t6_ext2_wrap", ext2, 1);
      chk("t6_ovf2", ovf2, 1);
      chk("t6_ovf8", ovf8, 0);

      // T6: disabled monitor ignores rco edges
      en = 1'b0; step();
      for (int k = 0; k < 3; k++) rco_pulse(4'(k));
      chk("t6_hold_ext", ext8, 9);
      chk("t6_hold_ext2", ext2, 1);
      chk("t6_no_evt", ev8.evt_valid, 0);

      // T1: reset with three queued events
      en = 1'b1; ready = 1'b0; q = 4'd0; step(); step();
      for (int k = 1; k <= 3; k++) rco_pulse(4'(k));
      chk("t1_queued", ev8.evt_valid, 1);
      rst = 1'b1; ready = 1'b1; step(); step();
      chk("t1_ext", ext8, 0);
      chk("t1_ovf2", ovf2, 0);
      chk("t1_load_val", lv8, 0);
      chk("t1_err", err8, 0);
      chk("t1_drop", drop8, 0);
      chk("t1_valid", ev8.evt_valid, 0);
      chk("t1_data", ev8.evt_data, 0);
      rst = 1'b0; step(); step();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
